// File: rtl/multi_rate_counter.sv
// Multi-channel gated edge counter: synchronises NCH async inputs and counts their
// edges over GATE_CYCLES-clock windows, either one-shot or back-to-back.
//
// state   | meaning
// IDLE    | no window open; working counters held at zero
// GATE    | window open; edges accumulate while the gate counter runs down
module multi_rate_counter #(
    parameter int NCH         = 4,
    parameter int CW          = 26,
    parameter int GATE_CYCLES = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int BOTH_EDGES  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NCH-1:0]    i_sig,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic              i_clear,
    output logic [NCH*CW-1:0] o_count,
    output logic [NCH-1:0]    o_ovf,
    output logic              o_valid,
    output logic              o_busy
);

    localparam int            GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q;
    logic [NCH-1:0] hist_q;
    logic [NCH-1:0] sync_out;
    logic [NCH-1:0] edge_p;
    logic [GW-1:0]  gate_q;
    logic [CW-1:0]  work_q  [NCH];
    logic [CW-1:0]  inc_val [NCH];
    logic [NCH-1:0] work_ovf_q;
    logic [NCH-1:0] sat_hit;
    logic           in_gate;
    logic           terminal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_sig};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (BOTH_EDGES != 0) begin : g_both
            assign edge_p = sync_out ^ hist_q;
        end else begin : g_rise
            assign edge_p = sync_out & ~hist_q;
        end
    endgenerate

    // i_clear overrides the window, so neither counting nor a result may happen on its cycle
    assign in_gate  = (state_q == ST_GATE) && !i_clear;
    assign terminal = in_gate && (gate_q == '0);
    assign o_busy   = (state_q == ST_GATE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (i_start) state_d = ST_GATE;
                ST_GATE: if ((gate_q == '0) && !i_mode) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gate_q <= '0;
        end else if (i_clear) begin
            gate_q <= '0;
        end else if (state_q == ST_IDLE) begin
            gate_q <= i_start ? GATE_LOAD : '0;
        end else if (gate_q == '0) begin
            gate_q <= i_mode ? GATE_LOAD : '0;
        end else begin
            gate_q <= gate_q - GW'(1);
        end
    end

    // The terminal cycle's own edge is folded into the latched result, not the next window
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            inc_val[k] = work_q[k];
            if (edge_p[k] && (work_q[k] != CNT_MAX)) begin
                inc_val[k] = work_q[k] + CW'(1);
            end
            sat_hit[k] = (inc_val[k] == CNT_MAX);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NCH; k++) work_q[k] <= '0;
            work_ovf_q <= '0;
        end else if (!in_gate || terminal) begin
            for (int k = 0; k < NCH; k++) work_q[k] <= '0;
            work_ovf_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) work_q[k] <= inc_val[k];
            work_ovf_q <= work_ovf_q | sat_hit;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= '0;
            o_ovf   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= terminal;
            if (terminal) begin
                for (int k = 0; k < NCH; k++) o_count[k*CW +: CW] <= inc_val[k];
                o_ovf <= work_ovf_q | sat_hit;
            end
        end
    end

endmodule

// File: doc/multi_rate_counter.md
Name: multi_rate_counter

Overview:
- Parametrised, multi-channel edge/rate counter for board-level clock and signal monitoring.
- Each of NCH asynchronous inputs is synchronised into i_clk, edge-detected, and counted over a programmable gate window of GATE_CYCLES clocks.
- Per-channel results are latched with a valid strobe, in one-shot or continuous mode, and feed the hex-display path.
- Generalises the fixed free-running per-clock counters: adds arbitrary channel count, counter width, edge mode, gated measurement, saturation and overflow flags.

Parameters:
NCH, 4, number of input channels (1..16)
CW, 26, per-channel count width in bits
GATE_CYCLES, 50000000, gate window length in i_clk cycles (>=2)
SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
BOTH_EDGES, 0, 0 = count rising edges only; 1 = count rising and falling edges

Ports:
i_clk  in  1  sole clock; all logic on its rising edge
i_rst_n  in  1  asynchronous active-low reset
i_sig  in  NCH  asynchronous inputs to measure; each must be slower than i_clk/2
i_start  in  1  one-cycle pulse that starts a measurement from IDLE
i_mode  in  1  0 = one-shot; 1 = continuous back-to-back windows
i_clear  in  1  synchronous abort: return to IDLE and zero working counters
o_count  out  NCH*CW  latched results; channel k occupies bits [k*CW +: CW]
o_ovf  out  NCH  per-channel saturation flag for the last latched window
o_valid  out  1  one-cycle pulse when o_count/o_ovf update
o_busy  out  1  high while a gate window is open

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state = IDLE.
  - o_count, o_ovf, o_valid, o_busy = 0.
  - Synchroniser chains, edge history, working counters and gate counter = 0.
- Synchroniser: SYNC_STAGES-flop chain per channel, then one history flop.
  - Rising edge: sync=1 and hist=0. Falling edge: sync=0 and hist=1.
  - An input transition produces an edge pulse SYNC_STAGES+1 cycles later.
  - Chains run continuously in every state.
- States:
  - IDLE: o_busy=0, working counters held at 0. i_start=1 -> GATE; gate counter loads GATE_CYCLES-1.
  - GATE: o_busy=1. Each cycle:
    - Each channel with an edge pulse increments its working counter.
    - At 2^CW-1 the counter holds and its working overflow bit sets.
    - Gate counter decrements.
  - Terminal GATE cycle (gate counter == 0), in the same clock edge:
    - o_count[k] <= working[k] + edge[k], saturating.
    - o_ovf[k] <= working ovf[k], or saturation reached in this cycle.
    - o_valid <= 1 for exactly one cycle.
    - Working counters and ovf <= 0.
    - i_mode=1: stay in GATE, reload GATE_CYCLES-1.
    - i_mode=0: go to IDLE.
- Windows are exactly GATE_CYCLES cycles. In continuous mode no edge is lost or double-counted across window boundaries.
- Latency: o_valid rises on the cycle after the terminal gate cycle, i.e. GATE_CYCLES+1 cycles after the i_start pulse.
- i_start while in GATE is ignored. i_mode is sampled only at the terminal cycle.
- i_clear has priority over everything except reset:
  - Next state = IDLE; working counters, ovf and gate counter = 0.
  - o_count, o_ovf and the previous results are retained; no o_valid.
  - i_clear and i_start in the same cycle: i_clear wins.
- Reset mid-window: immediate return to reset values; no partial result is emitted.
- BOTH_EDGES=1: rising and falling edge pulses both count; a channel counts at most one edge per cycle.

Test Plan:
- Bench setup for all scenarios: GATE_CYCLES=100, NCH=4, CW=8.
- Reset: assert i_rst_n low mid-GATE -> o_count=0, o_ovf=0, o_valid=0, o_busy=0 immediately, without waiting for a clock edge.
- One-shot count:
  - Stimulus: i_mode=0; i_start; ch0 gets 7 rising pulses (4 cycles high, 4 low) fully inside the window; ch1 idle.
  - Response: o_valid exactly once at cycle 101; ch0=7, ch1=0; o_busy returns to 0.
- Continuous boundary:
  - Stimulus: i_mode=1; ch2 driven with a square wave of period 10 cycles.
  - Response: successive o_valid pulses exactly 100 cycles apart. Each window reports 10 on ch2, and across any 5 windows the total equals the number of synchronised rising edges.
- Saturation: CW=4; ch3 toggles every 2 cycles for the 100-cycle window -> ch3 result = 15, o_ovf[3]=1, other o_ovf bits = 0.
- Clear and abort:
  - i_clear at cycle 50 of a window -> o_busy=0 next cycle, no o_valid, o_count keeps the previous window's values.
  - A subsequent i_start produces a fresh window counting from 0.
- Both edges: BOTH_EDGES=1; ch0 gets 5 full pulses -> ch0=10. An i_start while busy does not extend or restart the window.
